id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
Parametrised decode stage for the RISC-V core. It combines the register file, immediate generator, main control and ALU control with a registered ID/EX pipeline boundary. It adds a valid/ready handshake, load-use hazard stalling, flush, and illegal-opcode flagging. It sits between the IF stage and the EX stage.

Parameters:
XLEN, 32, datapath and register width in bits (32 or 64).
NREG, 32, number of architectural integer registers (16 or 32); index width is RW = clog2(NREG).
HAZARD_CHECK, 1, 1 = load-use stall logic enabled; 0 = stall logic tied off.

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  IF presents an instruction
o_ready  out  1  decode can accept this cycle
i_instruccion  in  32  instruction word
i_flush  in  1  squash the held ID/EX contents and the incoming instruction
i_RegWrite  in  1  write-back enable
i_WriteReg  in  RW  write-back register index
i_WriteData  in  XLEN  write-back data
o_valid  out  1  ID/EX bundle valid
i_ready  in  1  EX accepts the bundle
o_register1, o_register2  out  XLEN  rs1/rs2 values
o_constante  out  XLEN  sign-extended immediate
o_rs1, o_rs2, o_WriteReg  out  RW  source and destination indices
o_RegWrite, o_ALUSrc, o_MemWrite, o_MemRead, o_Branch, o_MemToReg, o_SLTc  out  1 each  control
o_ALUControl  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
o_BranchOp  out  2  00 BEQ, 01 BNE, 10 BLT, 11 BGE
o_illegal  out  1  opcode not decoded

Behaviour:
- Reset (async, i_rst_n=0): all registered outputs 0, o_valid=0, all registers 0. o_ready=1 once reset is released.
- Accept: i_valid & o_ready. Output register loads when (~o_valid | i_ready). Latency is 1 cycle from accept to o_valid.
- o_ready = (~o_valid | i_ready) & ~hazard.
- Hold: o_valid & ~i_ready keeps every output bit stable.
- Hazard (HAZARD_CHECK=1):
  - Condition: o_valid & o_MemRead & o_WriteReg!=0 & (o_WriteReg==rs1_used | o_WriteReg==rs2_used).
  - rs2 is used only for R, S and B formats.
  - When the register may load and a hazard exists, a bubble loads (o_valid=0, controls 0) and the instruction stays upstream. The stall lasts exactly 1 cycle.
- Flush: i_flush has priority over everything. Next edge: o_valid=0, all controls 0, incoming instruction dropped. o_ready is unaffected.
- Decode:
  - 0110011 (R): ALUSrc=0, RegWrite=1.
    - funct3 000: ADD, or SUB when funct7[5]=1.
    - 111: AND. 110: OR. 010: SLT. 011: SLT with SLTc=1.
  - 0010011 (I-ALU): same as R, but ALUSrc=1 and funct7 is ignored except on shifts. Unsupported funct3 -> o_illegal.
  - 0000011 (LW): ADD, ALUSrc, MemRead, MemToReg, RegWrite.
  - 0100011 (SW): ADD, ALUSrc, MemWrite.
  - 1100011 (Bxx): SUB, Branch=1, BranchOp from funct3 {000,001,100,101}.
  - Any other opcode: all controls 0, o_illegal=1, o_valid still 1.
- Immediates:
  - I: inst[31:20]. S: {inst[31:25], inst[11:7]}. B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - All sign-extended to XLEN. R-type immediate = 0.
- Register file:
  - Write on the rising edge when i_RegWrite & i_WriteReg!=0. x0 always reads 0.
  - Index bits above RW are ignored (NREG=16 uses inst[18:15], etc.).
- Stale hold: register values captured at accept are not refreshed while held. Forwarding in EX covers this.

Optional Feature:
ID_WB_BYPASS_EN:
- Defined: a same-cycle write-back to rs1/rs2 (index !=0) is forwarded combinationally into the captured o_register1/2.
- Undefined: the pre-write value is captured, and EX forwarding must supply the new value.

Test Plan:
- Reset mid-stream with o_valid=1 -> all outputs 0 immediately, o_valid=0; x5 reads 0 after release.
- Write x1=7 and x2=5, then accept 0x002081B3 (add x3,x1,x2) -> next cycle o_valid=1, o_register1=7, o_register2=5, o_ALUControl=010, o_RegWrite=1, o_WriteReg=3.
- Accept lw x5,4(x0), then add x6,x5,x1 back to back with i_ready=1 -> one bubble (o_valid=0) and o_ready=0 for 1 cycle, then the add appears; no stall if rd=x0.
- Hold i_ready=0 for 3 cycles with o_valid=1 -> outputs constant, o_ready=0; assert i_flush -> o_valid=0 next edge.
- Write x4=0xAA and read x4 in the same cycle -> captured 0xAA with ID_WB_BYPASS_EN, old value without; write to x0 -> x0 still reads 0.
- beq with imm=-8 (0xFE000CE3) -> o_constante=0xFFFFFFF8, o_Branch=1, o_BranchOp=00, o_ALUControl=110; opcode 0x7F -> o_illegal=1.

Source files
------------

// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe bus: IF-side valid/ready + instruction + flush,
// write-back port, and the registered ID/EX bundle towards EX.
// Ports: slave = decode stage, master = surrounding pipeline.
interface id_stage_pipe_if #(
  parameter int XLEN = 32,
  parameter int RW   = 5
);
  logic            i_valid;
  logic            o_ready;
  logic [31:0]     i_instruccion;
  logic            i_flush;
  logic            i_RegWrite;
  logic [RW-1:0]   i_WriteReg;
  logic [XLEN-1:0] i_WriteData;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_register1;
  logic [XLEN-1:0] o_register2;
  logic [XLEN-1:0] o_constante;
  logic [RW-1:0]   o_rs1;
  logic [RW-1:0]   o_rs2;
  logic [RW-1:0]   o_WriteReg;
  logic            o_RegWrite;
  logic            o_ALUSrc;
  logic            o_MemWrite;
  logic            o_MemRead;
  logic            o_Branch;
  logic            o_MemToReg;
  logic            o_SLTc;
  logic [2:0]      o_ALUControl;
  logic [1:0]      o_BranchOp;
  logic            o_illegal;

  modport slave (
    input  i_valid, i_instruccion, i_flush,
    input  i_RegWrite, i_WriteReg, i_WriteData, i_ready,
    output o_ready, o_valid,
    output o_register1, o_register2, o_constante,
    output o_rs1, o_rs2, o_WriteReg,
    output o_RegWrite, o_ALUSrc, o_MemWrite, o_MemRead,
    output o_Branch, o_MemToReg, o_SLTc,
    output o_ALUControl, o_BranchOp, o_illegal
  );

  modport master (
    output i_valid, i_instruccion, i_flush,
    output i_RegWrite, i_WriteReg, i_WriteData, i_ready,
    input  o_ready, o_valid,
    input  o_register1, o_register2, o_constante,
    input  o_rs1, o_rs2, o_WriteReg,
    input  o_RegWrite, o_ALUSrc, o_MemWrite, o_MemRead,
    input  o_Branch, o_MemToReg, o_SLTc,
    input  o_ALUControl, o_BranchOp, o_illegal
  );
endinterface

// File: rtl/id_stage_pipe.sv
// Decode stage: regfile, imm gen, control, ALU ctl, ID/EX register with
// valid/ready, load-use stall, flush, illegal flag. Ports: i_clk, i_rst_n
// (async low), bus (id_stage_pipe_if.slave). Macro ID_WB_BYPASS_EN: same-cycle WB->read bypass.
module id_stage_pipe #(
  parameter int XLEN         = 32,
  parameter int NREG         = 32,
  parameter int HAZARD_CHECK = 1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  id_stage_pipe_if.slave bus
);
  localparam int RW = $clog2(NREG);

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   wr;
    logic            reg_write;
    logic            alu_src;
    logic            mem_write;
    logic            mem_read;
    logic            branch;
    logic            mem_to_reg;
    logic            sltc;
    logic [2:0]      alu_ctl;
    logic [1:0]      br_op;
    logic            illegal;
  } id_ex_t;

  id_ex_t          ex_d, ex_q, dec;
  logic [XLEN-1:0] rf_d [NREG];
  logic [XLEN-1:0] rf_q [NREG];

  logic [31:0]     inst;
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [RW-1:0]   rs1, rs2;
  logic            is_r, is_i, is_l, is_s, is_b;
  logic            wb_en, hazard, load;
  logic [XLEN-1:0] imm_i, imm_s, imm_b;
  logic [XLEN-1:0] rd1, rd2;
  logic            unused_inst;

  assign inst = bus.i_instruccion;
  assign opc  = inst[6:0];
  assign f3   = inst[14:12];
  assign rs1  = inst[15 +: RW];
  assign rs2  = inst[20 +: RW];
  // index bits above RW are intentionally dropped
  assign unused_inst = ^inst;

  assign is_r = (opc == OP_R);
  assign is_i = (opc == OP_I);
  assign is_l = (opc == OP_L);
  assign is_s = (opc == OP_S);
  assign is_b = (opc == OP_B);

  assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25],
                  inst[11:8], 1'b0};

  assign wb_en = bus.i_RegWrite & (bus.i_WriteReg != '0);

  always_comb begin
    rd1 = rf_q[rs1];
    rd2 = rf_q[rs2];
`ifdef ID_WB_BYPASS_EN
    if (wb_en && bus.i_WriteReg == rs1) rd1 = bus.i_WriteData;
    if (wb_en && bus.i_WriteReg == rs2) rd2 = bus.i_WriteData;
`endif
  end

  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.rd1   = rd1;
    dec.rd2   = rd2;
    dec.rs1   = rs1;
    dec.rs2   = rs2;
    dec.wr    = inst[7 +: RW];
    unique case (1'b1)
      is_r, is_i: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = is_i;
        dec.imm       = is_i ? imm_i : '0;
        unique case (f3)
          3'b000: dec.alu_ctl = (is_r && inst[30]) ? ALU_SUB : ALU_ADD;
          3'b111: dec.alu_ctl = ALU_AND;
          3'b110: dec.alu_ctl = ALU_OR;
          3'b010: dec.alu_ctl = ALU_SLT;
          3'b011: begin
            dec.alu_ctl = ALU_SLT;
            dec.sltc    = 1'b1;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      is_l: begin
        dec.alu_ctl    = ALU_ADD;
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.imm        = imm_i;
      end
      is_s: begin
        dec.alu_ctl   = ALU_ADD;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.imm       = imm_s;
      end
      is_b: begin
        dec.alu_ctl = ALU_SUB;
        dec.branch  = 1'b1;
        dec.imm     = imm_b;
        unique case (f3)
          3'b000:  dec.br_op = 2'b00;
          3'b001:  dec.br_op = 2'b01;
          3'b100:  dec.br_op = 2'b10;
          3'b101:  dec.br_op = 2'b11;
          default: dec.illegal = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
    // an undecodable word travels as a flagged no-op
    if (dec.illegal) begin
      dec.reg_write  = 1'b0;
      dec.alu_src    = 1'b0;
      dec.mem_write  = 1'b0;
      dec.mem_read   = 1'b0;
      dec.branch     = 1'b0;
      dec.mem_to_reg = 1'b0;
      dec.sltc       = 1'b0;
      dec.alu_ctl    = '0;
      dec.br_op      = '0;
      dec.imm        = '0;
    end
  end

  generate
    if (HAZARD_CHECK != 0) begin : g_hz
      logic use1, use2;
      assign use1 = is_r | is_i | is_l | is_s | is_b;
      assign use2 = is_r | is_s | is_b;
      assign hazard = ex_q.valid & ex_q.mem_read & (ex_q.wr != '0) &
                      ((use1 & (ex_q.wr == rs1)) |
                       (use2 & (ex_q.wr == rs2)));
    end else begin : g_nohz
      assign hazard = 1'b0;
    end
  endgenerate

  assign load        = ~ex_q.valid | bus.i_ready;
  assign bus.o_ready = load & ~hazard;

  always_comb begin
    ex_d = ex_q;
    if (bus.i_flush) begin
      ex_d = '0;
    end else if (load) begin
      // hazard or no input: bubble, instruction waits upstream
      ex_d = (bus.i_valid && !hazard) ? dec : '0;
    end
  end

  always_comb begin
    rf_d = rf_q;
    if (wb_en) rf_d[bus.i_WriteReg] = bus.i_WriteData;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_q <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      ex_q <= ex_d;
      rf_q <= rf_d;
    end
  end

  assign bus.o_valid      = ex_q.valid;
  assign bus.o_register1  = ex_q.rd1;
  assign bus.o_register2  = ex_q.rd2;
  assign bus.o_constante  = ex_q.imm;
  assign bus.o_rs1        = ex_q.rs1;
  assign bus.o_rs2        = ex_q.rs2;
  assign bus.o_WriteReg   = ex_q.wr;
  assign bus.o_RegWrite   = ex_q.reg_write;
  assign bus.o_ALUSrc     = ex_q.alu_src;
  assign bus.o_MemWrite   = ex_q.mem_write;
  assign bus.o_MemRead    = ex_q.mem_read;
  assign bus.o_Branch     = ex_q.branch;
  assign bus.o_MemToReg   = ex_q.mem_to_reg;
  assign bus.o_SLTc       = ex_q.sltc;
  assign bus.o_ALUControl = ex_q.alu_ctl;
  assign bus.o_BranchOp   = ex_q.br_op;
  assign bus.o_illegal    = ex_q.illegal;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed steps from the test plan, then
// random traffic checked against a behavioural decode/pipeline model.
module tb_id_stage_pipe;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int RW   = $clog2(NREG);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_stage_pipe_if #(.XLEN(XLEN), .RW(RW)) bus ();

  id_stage_pipe #(
    .XLEN(XLEN), .NREG(NREG), .HAZARD_CHECK(1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] r1, r2, imm;
    logic [RW-1:0]   rs1, rs2, wr;
    logic            regwrite, alusrc, memwrite, memread;
    logic            branch, memtoreg, sltc;
    logic [2:0]      aluc;
    logic [1:0]      bop;
    logic            ill;
  } exp_t;

  exp_t            m;
  exp_t            snap;
  logic [XLEN-1:0] mreg [NREG];
  int              checks = 0;
  int              failures = 0;
  logic            acc;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t observed();
    exp_t o;
    o.valid = bus.o_valid;       o.r1 = bus.o_register1;
    o.r2 = bus.o_register2;      o.imm = bus.o_constante;
    o.rs1 = bus.o_rs1;           o.rs2 = bus.o_rs2;
    o.wr = bus.o_WriteReg;       o.regwrite = bus.o_RegWrite;
    o.alusrc = bus.o_ALUSrc;     o.memwrite = bus.o_MemWrite;
    o.memread = bus.o_MemRead;   o.branch = bus.o_Branch;
    o.memtoreg = bus.o_MemToReg; o.sltc = bus.o_SLTc;
    o.aluc = bus.o_ALUControl;   o.bop = bus.o_BranchOp;
    o.ill = bus.o_illegal;
    return o;
  endfunction

  function automatic logic [XLEN-1:0] to_x(input int v);
    longint l;
    l = v;
    return l[XLEN-1:0];
  endfunction

  function automatic logic [XLEN-1:0] rdreg(input int idx, input logic wb,
      input int widx, input logic [XLEN-1:0] wd);
    logic [XLEN-1:0] r;
    r = (idx == 0) ? '0 : mreg[idx];
`ifdef ID_WB_BYPASS_EN
    if (wb && widx != 0 && widx == idx) r = wd;
`endif
    return r;
  endfunction

  // Decode straight from the ISA field rules with integer arithmetic.
  function automatic exp_t mdecode(input logic [31:0] in, input logic wb,
      input int widx, input logic [XLEN-1:0] wd);
    exp_t e;
    int op, f3, a, b, d, v;
    bit bad;
    e = '0;
    op = in[6:0]; f3 = in[14:12];
    a = in[19:15] % NREG; b = in[24:20] % NREG; d = in[11:7] % NREG;
    e.valid = 1'b1;
    e.rs1 = RW'(a); e.rs2 = RW'(b); e.wr = RW'(d);
    e.r1 = rdreg(a, wb, widx, wd);
    e.r2 = rdreg(b, wb, widx, wd);
    bad = 0;
    case (op)
      'h33, 'h13: begin
        e.regwrite = 1; e.alusrc = (op == 'h13);
        v = in[31:20]; if (v >= 2048) v -= 4096;
        if (op == 'h13) e.imm = to_x(v);
        case (f3)
          0: e.aluc = (op == 'h33 && in[30]) ? 3'd6 : 3'd2;
          7: e.aluc = 3'd0;
          6: e.aluc = 3'd1;
          2: e.aluc = 3'd7;
          3: begin e.aluc = 3'd7; e.sltc = 1; end
          default: bad = 1;
        endcase
      end
      'h03: begin
        v = in[31:20]; if (v >= 2048) v -= 4096;
        e.imm = to_x(v); e.aluc = 3'd2; e.alusrc = 1;
        e.memread = 1; e.memtoreg = 1; e.regwrite = 1;
      end
      'h23: begin
        v = in[31:25] * 32 + in[11:7]; if (v >= 2048) v -= 4096;
        e.imm = to_x(v); e.aluc = 3'd2; e.alusrc = 1; e.memwrite = 1;
      end
      'h63: begin
        v = in[31] * 4096 + in[7] * 2048 + in[30:25] * 32 + in[11:8] * 2;
        if (v >= 4096) v -= 8192;
        e.imm = to_x(v); e.aluc = 3'd6; e.branch = 1;
        case (f3)
          0: e.bop = 2'd0;
          1: e.bop = 2'd1;
          4: e.bop = 2'd2;
          5: e.bop = 2'd3;
          default: bad = 1;
        endcase
      end
      default: bad = 1;
    endcase
    if (bad) begin
      e.imm = '0; e.regwrite = 0; e.alusrc = 0; e.memwrite = 0;
      e.memread = 0; e.branch = 0; e.memtoreg = 0; e.sltc = 0;
      e.aluc = '0; e.bop = '0; e.ill = 1;
    end
    return e;
  endfunction

  function automatic bit mhazard(input logic [31:0] in);
    int op, a, b, w;
    bit u1, u2;
    op = in[6:0];
    a = in[19:15] % NREG; b = in[24:20] % NREG; w = m.wr;
    u1 = (op == 'h33 || op == 'h13 || op == 'h03 || op == 'h23 || op == 'h63);
    u2 = (op == 'h33 || op == 'h23 || op == 'h63);
    return m.valid && m.memread && w != 0 && ((u1 && w == a) || (u2 && w == b));
  endfunction

  task automatic cycle(input logic v, input logic [31:0] in, input logic fl,
      input logic rdy, input logic wb, input int widx,
      input logic [XLEN-1:0] wd, output logic ac);
    bit hz, ld, rexp;
    exp_t nm;
    bus.i_valid = v; bus.i_instruccion = in; bus.i_flush = fl;
    bus.i_ready = rdy; bus.i_RegWrite = wb;
    bus.i_WriteReg = RW'(widx); bus.i_WriteData = wd;
    #1;
    hz = mhazard(in);
    ld = !m.valid || rdy;
    rexp = ld && !hz;
    chk("o_ready", bus.o_ready, rexp);
    ac = v && rexp;
    if (fl) nm = '0;
    else if (ld) nm = (v && !hz) ? mdecode(in, wb, widx, wd) : '0;
    else nm = m;
    if (wb && widx != 0) mreg[widx] = wd;
    m = nm;
    @(posedge clk);
    #1;
    chk("id_ex", observed(), m);
  endtask

  task automatic wr(input int idx, input logic [XLEN-1:0] d);
    logic a;
    cycle(0, 32'h13, 0, 1, 1, idx, d, a);
  endtask

  task automatic send(input logic [31:0] in);
    logic a;
    a = 0;
    for (int k = 0; k < 10 && !a; k++) cycle(1, in, 0, 1, 0, 0, '0, a);
    chk("send_bound", a, 1);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: r[6:0] = 7'h33;
      1: r[6:0] = 7'h13;
      2, 3: r[6:0] = 7'h03;
      4: r[6:0] = 7'h23;
      5: r[6:0] = 7'h63;
      default: ;
    endcase
    if ($urandom_range(0, 1) == 1) begin
      r[19:15] = 5'($urandom_range(0, 3));
      r[24:20] = 5'($urandom_range(0, 3));
      r[11:7]  = 5'($urandom_range(0, 3));
    end
    return r;
  endfunction

  initial begin
    logic [31:0] pend;
    logic v, rdy, fl, wb;
    int widx;
    logic [XLEN-1:0] wd;
    logic [XLEN-1:0] b4;

    m = '0;
    for (int i = 0; i < NREG; i++) mreg[i] = '0;
    bus.i_valid = 0; bus.i_instruccion = '0; bus.i_flush = 0;
    bus.i_ready = 1; bus.i_RegWrite = 0; bus.i_WriteReg = '0;
    bus.i_WriteData = '0;
    #2;
    chk("reset_state", observed(), '0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", bus.o_ready, 1);

    wr(1, 7);
    wr(2, 5);
    send(32'h002081B3);
    chk("add_valid", bus.o_valid, 1);
    chk("add_r1", bus.o_register1, 7);
    chk("add_r2", bus.o_register2, 5);
    chk("add_aluc", bus.o_ALUControl, 3'b010);
    chk("add_regwrite", bus.o_RegWrite, 1);
    chk("add_wr", bus.o_WriteReg, 3);

    send(32'h00402283);
    cycle(1, 32'h00128333, 0, 1, 0, 0, '0, acc);
    chk("stall_acc", acc, 0);
    chk("bubble_valid", bus.o_valid, 0);
    cycle(1, 32'h00128333, 0, 1, 0, 0, '0, acc);
    chk("after_stall_acc", acc, 1);
    chk("after_stall_wr", bus.o_WriteReg, 6);
    send(32'h00402003);
    cycle(1, 32'h00100333, 0, 1, 0, 0, '0, acc);
    chk("x0_nostall_acc", acc, 1);

    send(32'h002081B3);
    snap = observed();
    for (int k = 0; k < 3; k++) begin
      cycle(1, 32'h00100333, 0, 0, 0, 0, '0, acc);
      chk("hold_bundle", observed(), snap);
      chk("hold_ready", bus.o_ready, 0);
    end
    cycle(1, 32'h00100333, 1, 0, 0, 0, '0, acc);
    chk("flush_valid", bus.o_valid, 0);

    cycle(1, 32'h000203B3, 0, 1, 1, 4, 'hAA, acc);
`ifdef ID_WB_BYPASS_EN
    b4 = 'hAA;
`else
    b4 = '0;
`endif
    chk("wb_same_cycle_r1", bus.o_register1, b4);
    wr(0, 'h1234);
    send(32'h000003B3);
    chk("x0_reads_zero", bus.o_register1, 0);

    send(32'hFE000CE3);
    chk("beq_imm", bus.o_constante, 32'hFFFFFFF8);
    chk("beq_branch", bus.o_Branch, 1);
    chk("beq_bop", bus.o_BranchOp, 2'b00);
    chk("beq_aluc", bus.o_ALUControl, 3'b110);
    send(32'h0000007F);
    chk("illegal_flag", bus.o_illegal, 1);
    chk("illegal_valid", bus.o_valid, 1);

    wr(5, 'h55);
    cycle(1, 32'h002081B3, 0, 0, 0, 0, '0, acc);
    chk("pre_reset_valid", bus.o_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_bundle", observed(), '0);
    m = '0;
    for (int i = 0; i < NREG; i++) mreg[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(32'h00028433);
    chk("x5_after_reset", bus.o_register1, 0);

    pend = rand_inst();
    for (int i = 0; i < 500; i++) begin
      v = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 15) == 0);
      wb = ($urandom_range(0, 1) == 1);
      widx = $urandom_range(0, NREG - 1);
      wd = XLEN'({$urandom, $urandom});
      cycle(v, pend, fl, rdy, wb, widx, wd, acc);
      if (acc) pend = rand_inst();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
